// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider: default ratio width and the
// smallest ratio that actually divides.
package clk_div_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int MIN_RATIO = 2;
endpackage

// File: rtl/clk_mux2.sv
// Two-input clock select; kept as its own cell so a glitch-safe library
// clock mux can be dropped in without touching the divider.
module clk_mux2 (
  input  logic i_clk0,
  input  logic i_clk1,
  input  logic i_sel,
  output logic o_clk
);
  assign o_clk = i_sel ? i_clk1 : i_clk0;
endmodule

// File: rtl/clk_div.sv
// Integer clock divider: high for floor(N/2) ref cycles, low for ceil(N/2).
// Ratios below MIN_RATIO, or a cleared enable, pass the reference straight through.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic [DIV_W-1:0] i_div_ratio,
  output logic             o_div_clk
);
  logic [DIV_W-1:0] r_cnt;
  logic             r_div_q;
  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_last;
  logic             w_bypass;

  assign w_bypass = !i_clk_en || (i_div_ratio < DIV_W'(MIN_RATIO));
  assign w_half   = i_div_ratio >> 1;
  // Only used outside bypass, where N >= 2, so N-1 cannot underflow.
  assign w_last   = i_div_ratio - 1'b1;

  always_ff @(posedge i_ref_clk) begin
    if (i_rst || w_bypass) begin
      // Parking at zero makes the next enabled edge start a fresh period.
      r_cnt   <= '0;
      r_div_q <= 1'b0;
    end else begin
      r_div_q <= (r_cnt < w_half);
      // >= rather than == so a ratio shrunk below the count still wraps.
      r_cnt   <= (r_cnt >= w_last) ? '0 : r_cnt + 1'b1;
    end
  end

  clk_mux2 u_mux (
    .i_clk0 (r_div_q),
    .i_clk1 (i_ref_clk),
    .i_sel  (w_bypass),
    .o_clk  (o_div_clk)
  );
endmodule

// File: tb/tb_clk_div.sv
// Scoreboard bench for clk_div: two instances share reset/enable, each gets
// its own ratio; the driver queues hand-computed levels, a monitor checks them.
module tb_clk_div;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [7:0] na  = 8'd2;
  logic [7:0] nb  = 8'd2;
  logic       o_a, o_b;
  logic       hi_a, hi_b;

  typedef struct {
    logic a;
    logic b;
    logic byp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  always #5 clk = ~clk;

  clk_div #(.DIV_W(8)) dut_a (
    .i_ref_clk (clk), .i_rst (rst), .i_clk_en (en),
    .i_div_ratio (na), .o_div_clk (o_a)
  );
  clk_div #(.DIV_W(8)) dut_b (
    .i_ref_clk (clk), .i_rst (rst), .i_clk_en (en),
    .i_div_ratio (nb), .o_div_clk (o_b)
  );

  // Level seen during the high phase of the reference (used for bypass).
  always @(posedge clk) begin
    #1;
    hi_a = o_a;
    hi_b = o_b;
  end

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is a check.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("out_a_low", o_a, e.a);
      chk("out_b_low", o_b, e.b);
      if (e.byp) begin
        chk("byp_a_high", hi_a, 1'b1);
        chk("byp_b_high", hi_b, 1'b1);
      end
    end
  end

  // Drive inputs for the coming rising edge and queue the level expected
  // at the falling edge after it.
  task automatic cyc(input logic r, input logic e, input logic [7:0] ra,
                     input logic [7:0] rb, input logic ea, input logic eb,
                     input logic byp);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; en = e; na = ra; nb = rb;
    x.a = ea; x.b = eb; x.byp = byp;
    sb.push_back(x);
  endtask

  task automatic seq(input logic [7:0] ra, input logic [7:0] rb,
                     input string pa, input string pb);
    for (int i = 0; i < pa.len(); i++)
      cyc(1'b0, 1'b1, ra, rb, pa[i] == "1", pb[i] == "1", 1'b0);
  endtask

  task automatic do_rst(input int n, input logic [7:0] ra, input logic [7:0] rb);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, ra, rb, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset then N=2 on both instances.
    do_rst(2, 8'd2, 8'd2);
    seq(8'd2, 8'd2, "101010101010", "101010101010");
    // Odd ratios in parallel.
    do_rst(1, 8'd3, 8'd5);
    seq(8'd3, 8'd5, "100100100100100", "110001100011000");
    // Even ratios: 50% duty.
    do_rst(1, 8'd4, 8'd6);
    seq(8'd4, 8'd6, "110011001100", "111000111000");
    // Bypass via N=0 / N=1, then via en=0; output follows the reference.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'd0, 8'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'd4, 8'd6, 1'b0, 1'b0, 1'b1);
    // Leaving bypass restarts with a high phase.
    seq(8'd4, 8'd6, "11001100", "11100011");
    // Reset mid-period: A (N=5) at cnt=3, B (N=3) alongside.
    do_rst(1, 8'd5, 8'd3);
    seq(8'd5, 8'd3, "110", "100");
    do_rst(1, 8'd5, 8'd3);
    seq(8'd5, 8'd3, "1100011000", "1001001001");
    // Ratio shrink at cnt=4: A 6->3, B 5->2; one low cycle for the wrap.
    do_rst(1, 8'd6, 8'd5);
    seq(8'd6, 8'd5, "1110", "1100");
    seq(8'd3, 8'd2, "0100100100", "0101010101");
    // Drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 Parameter DIV_W, default 8, width of the ratio input and the internal counter.
REQ-002 i_ref_clk  input  1  reference clock; the design's only clock; all flops on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high; sampled on the rising edge of i_ref_clk.
REQ-004 i_clk_en  input  1  divider enable; 0 selects bypass.
REQ-005 i_div_ratio  input  DIV_W  integer divide ratio N; unsigned.
REQ-006 o_div_clk  output  1  divided clock, or i_ref_clk when in bypass.

Function
REQ-007 Bypass condition SHALL be i_clk_en==0 OR i_div_ratio<2; in bypass, o_div_clk SHALL equal i_ref_clk combinationally, independent of i_rst.
REQ-008 Outside bypass, o_div_clk SHALL be the registered output div_q; no combinational path from i_ref_clk to the output.
REQ-009 Internal state: counter cnt (DIV_W bits) and flop div_q; H = floor(N/2), a right shift of i_div_ratio by 1.
REQ-010 On each rising edge, when not in reset and not in bypass: div_q <= (cnt < H); cnt <= 0 if cnt >= N-1, else cnt+1.
REQ-011 Resulting waveform: period N ref cycles; high for floor(N/2) cycles, then low for ceil(N/2) cycles; duty exactly 50% for even N.
REQ-012 Examples: N=2 -> 1H/1L; N=3 -> 1H/2L; N=4 -> 2H/2L; N=5 -> 2H/3L; N=6 -> 3H/3L.
REQ-013 Phase: the first enabled rising edge after reset SHALL drive div_q to 1; each later period starts with div_q rising on the edge where cnt==0.
REQ-014 While in bypass, on each rising edge cnt <= 0 and div_q <= 0, so leaving bypass restarts cleanly at REQ-013 phase.
REQ-015 Ratio change mid-period: the new N and H take effect on the next edge; cnt >= new N-1 SHALL wrap to 0, giving no lock-up or overflow.
REQ-016 Maximum N = 2^DIV_W - 1; cnt never exceeds N-1, and all arithmetic is unsigned DIV_W bits.

Reset
REQ-017 When i_rst==1 at a rising edge: cnt <= 0 and div_q <= 0; outside bypass, o_div_clk SHALL then read 0.
REQ-018 Reset SHALL take priority over enable and ratio; reset mid-period aborts the period, and the first edge after release SHALL follow REQ-013.
REQ-019 Before the first reset edge, state is undefined; the bench SHALL reset before checking.

Structure
REQ-020 Shared package clk_div_pkg SHALL hold DIV_W default (8) and MIN_RATIO constant (2).
REQ-021 The output clock-select mux SHALL be a separate sub-module clk_mux2 (inputs: two clocks, a select; output: one clock), so it can be replaced by a glitch-safe library cell.
REQ-022 Counter and div_q logic reside in clk_div; no other sub-modules.

Verification
REQ-023 Reset 2 cycles, then en=1, N=2; sample at falling edges over 12 cycles -> output 1,0,1,0,...
REQ-024 N=3 and N=5 in parallel instances, same stimulus -> N=3 gives 1,0,0 repeating; N=5 gives 1,1,0,0,0 repeating.
REQ-025 N=4 and N=6 -> N=4 gives 1,1,0,0 repeating; N=6 gives 1,1,1,0,0,0 repeating.
REQ-026 N=0, N=1, or en=0 -> o_div_clk tracks i_ref_clk exactly; on switching to N=4 with en=1, the first divided edge produces 1, then the REQ-025 pattern.
REQ-027 N=5 running, assert i_rst for 1 cycle at cnt=3 -> output 0 during reset, then 1,1,0,0,0 from the first edge after release.
REQ-028 N=6 running, change to N=3 at cnt=4 -> cnt wraps to 0 on the next edge, then a steady 1,0,0 pattern with no stuck state.
